// File: rtl/op_pipe_acc.sv
// op_pipe_acc: two-stage operand pipeline feeding a DEPTH-entry result FIFO.
// Stage 1 registers an accepted operand pair. Stage 2 computes one of
// add / sub / sat-add / accumulate and pushes {overflow, result} into the FIFO.
// Admission is credit based: a pair is only taken when the FIFO is guaranteed
// to have room for it, so a push can never be dropped.
module op_pipe_acc #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  operand_A,
  input  logic [W-1:0]  operand_B,
  input  logic [1:0]    op,
  input  logic          in_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  result_data,
  output logic          overflow,
  output logic [CW-1:0] fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SAT = 2'b10;
  localparam logic [1:0] OP_ACC = 2'b11;
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  // Stage 1 and accumulator state
  logic          s1_valid_q, s1_valid_d;
  logic [1:0]    s1_op_q, s1_op_d;
  logic [W-1:0]  s1_a_q, s1_a_d;
  logic [W-1:0]  s1_b_q, s1_b_d;
  logic          s1_clr_q, s1_clr_d;
  logic [W-1:0]  acc_q, acc_d;

  // FIFO bookkeeping
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  fifo_mem_res [DEPTH];
  logic          fifo_mem_ovf [DEPTH];

  logic          accept;
  logic          push;
  logic          pop;
  logic [CW:0]   credit_used;
  logic [W-1:0]  acc_base;
  logic [W:0]    sum_ab;
  logic [W:0]    diff_ab;
  logic [W:0]    sum_acc;
  logic [W-1:0]  res;
  logic          res_ovf;

  // Entries already in the FIFO plus the one in stage 1 must leave a free slot.
  assign credit_used = {1'b0, count_q} + {{CW{1'b0}}, s1_valid_q};
  assign in_ready    = reset && (credit_used < DEPTH_C);
  assign accept      = in_valid && in_ready;
  assign push        = s1_valid_q;
  assign out_valid   = (count_q != '0);
  assign pop         = out_valid && out_ready;
  assign result_data = out_valid ? fifo_mem_res[rd_ptr_q] : '0;
  assign overflow    = out_valid ? fifo_mem_ovf[rd_ptr_q] : 1'b0;
  assign fifo_count  = count_q;

  // Stage 2 arithmetic on the registered operands
  always_comb begin
    acc_base = s1_clr_q ? '0 : acc_q;
    sum_ab   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    diff_ab  = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    sum_acc  = {1'b0, acc_base} + {1'b0, s1_a_q};
    res      = sum_ab[W-1:0];
    res_ovf  = sum_ab[W];
    case (s1_op_q)
      OP_SUB: begin
        // The extra MSB of the widened difference is the borrow (A < B).
        res     = diff_ab[W-1:0];
        res_ovf = diff_ab[W];
      end
      OP_SAT: begin
        res     = sum_ab[W] ? '1 : sum_ab[W-1:0];
        res_ovf = sum_ab[W];
      end
      OP_ACC: begin
        res     = sum_acc[W-1:0];
        res_ovf = sum_acc[W];
      end
      default: begin
      end
    endcase
  end

  // Next-state for stage 1, accumulator and FIFO pointers/occupancy
  always_comb begin
    s1_valid_d = accept;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_clr_d   = s1_clr_q;
    acc_d      = acc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (accept) begin
      s1_op_d  = op;
      s1_a_d   = operand_A;
      s1_b_d   = operand_B;
      s1_clr_d = in_clr;
    end
    if (s1_valid_q) begin
      if (s1_op_q == OP_ACC) begin
        acc_d = res;
      end else if (s1_clr_q) begin
        acc_d = '0;
      end
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; an unknown reset drives the state unknown rather than hiding it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_clr_q   <= 1'b0;
      acc_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else if (reset) begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_clr_q   <= s1_clr_d;
      acc_q      <= acc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end else begin
      s1_valid_q <= 'x;
      s1_op_q    <= 'x;
      s1_a_q     <= 'x;
      s1_b_q     <= 'x;
      s1_clr_q   <= 'x;
      acc_q      <= 'x;
      wr_ptr_q   <= 'x;
      rd_ptr_q   <= 'x;
      count_q    <= 'x;
    end
  end

  // FIFO storage write; contents need no reset because reads are gated by occupancy
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_res[wr_ptr_q] <= res;
      fifo_mem_ovf[wr_ptr_q] <= res_ovf;
    end
  end

endmodule

// File: tb/tb_op_pipe_acc.sv
// Self-checking bench for op_pipe_acc: a reference model pushes expected
// {overflow, result} words into a queue on every accepted transaction and
// each scenario pops and compares them as the FIFO delivers results.
module tb_op_pipe_acc;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SAT = 2'b10;
  localparam logic [1:0] OP_ACC = 2'b11;

  logic          clk = 1'b1;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  operand_A;
  logic [W-1:0]  operand_B;
  logic [1:0]    op;
  logic          in_clr;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result_data;
  logic          overflow;
  logic [CW-1:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W:0] exp_q[$];
  logic [W-1:0] model_acc = '0;

  op_pipe_acc #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operand_A  (operand_A),
    .operand_B  (operand_B),
    .op         (op),
    .in_clr     (in_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_data(result_data),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Offer one transaction for one cycle (called on a falling edge). When the
  // block is ready the model result is queued. Returns at the next falling edge.
  task automatic drive(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic clr, output bit accepted);
    logic [W:0]   s;
    logic [W:0]   e;
    logic [W-1:0] base;
    op = o; operand_A = a; operand_B = b; in_clr = clr; in_valid = 1'b1;
    accepted = (in_ready === 1'b1);
    if (accepted) begin
      case (o)
        OP_ADD: e = {1'b0, a} + {1'b0, b};
        OP_SUB: e = {(a < b), a - b};
        OP_SAT: begin
          s = {1'b0, a} + {1'b0, b};
          e = s[W] ? {1'b1, {W{1'b1}}} : s;
        end
        default: begin
          base = clr ? '0 : model_acc;
          e = {1'b0, base} + {1'b0, a};
          model_acc = e[W-1:0];
        end
      endcase
      if (o != OP_ACC && clr) model_acc = '0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_clr   = 1'b0;
  endtask

  // Wait (bounded) for a head entry, capture it and pop it.
  task automatic take(output logic [W:0] got, output bit seen);
    seen = 1'b0;
    got  = 'x;
    for (int c = 0; c < 20; c++) begin
      if (out_valid === 1'b1) begin
        got = {overflow, result_data};
        seen = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  function automatic logic [W:0] next_exp();
    if (exp_q.size() > 0) return exp_q.pop_front();
    return 'x;
  endfunction

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; operand_A = '0; operand_B = '0;
    op = OP_ADD; in_clr = 1'b0; out_ready = 1'b0;
    #4;
    n_checks++;
    if ({out_valid, fifo_count, result_data, overflow, in_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected 0",
               {out_valid, fifo_count, result_data, overflow, in_ready});
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b, expected 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_add();
    bit ok, seen;
    logic [W:0] got, exp;
    drive(OP_ADD, 16'd4, 16'd7, 1'b0, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL add_accept: got %b, expected 1", ok); end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_not_fallthrough: out_valid %b, expected 0", out_valid);
    end
    @(negedge clk);
    n_checks++;
    if ({out_valid, fifo_count, overflow, result_data} !== {1'b1, 3'd1, 1'b0, 16'd11}) begin
      n_fail++;
      $display("FAIL add_result: got v=%b cnt=%0d ovf=%b r=%h, expected v=1 cnt=1 ovf=0 r=000b",
               out_valid, fifo_count, overflow, result_data);
    end
    @(negedge clk);
    n_checks++;
    if ({out_valid, overflow, result_data} !== {1'b1, 1'b0, 16'd11}) begin
      n_fail++;
      $display("FAIL add_hold: got v=%b ovf=%b r=%h, expected held 000b", out_valid, overflow, result_data);
    end
    take(got, seen);
    exp = next_exp();
    n_checks++;
    if (!seen || got !== exp) begin
      n_fail++; $display("FAIL add_scoreboard: got %h, expected %h", got, exp);
    end
    $display("txn add got=%h exp=%h", got, exp);
    n_checks++;
    if ({out_valid, fifo_count, result_data} !== '0) begin
      n_fail++; $display("FAIL add_empty: got v=%b cnt=%0d r=%h, expected 0", out_valid, fifo_count, result_data);
    end
  endtask

  task automatic test_arith();
    logic [1:0]   t_op [6];
    logic [W-1:0] t_a [6];
    logic [W-1:0] t_b [6];
    logic [W:0]   t_exp [6];
    bit ok, seen;
    int j;
    logic [W:0] got, exp;
    t_op  = '{OP_SUB, OP_SAT, OP_ADD, OP_SAT, OP_SUB, OP_SAT};
    t_a   = '{16'h0000, 16'hFFF0, 16'hFFFF, 16'h0001, 16'h0007, 16'h8000};
    t_b   = '{16'h0006, 16'h0020, 16'h0001, 16'h0002, 16'h0003, 16'h7FFF};
    t_exp = '{17'h1FFFA, 17'h1FFFF, 17'h10000, 17'h00003, 17'h00004, 17'h0FFFF};
    j = 0;
    for (int i = 0; i < 6; i++) begin
      drive(t_op[i], t_a[i], t_b[i], 1'b0, ok);
      n_checks++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL arith_accept[%0d]: got %b, expected 1", i, ok); end
      if (i % 3 == 2) begin
        while (j <= i) begin
          take(got, seen);
          exp = next_exp();
          n_checks++;
          if (!seen || got !== exp || got !== t_exp[j]) begin
            n_fail++;
            $display("FAIL arith_result[%0d]: got %h, expected %h (table %h)", j, got, exp, t_exp[j]);
          end
          $display("txn arith[%0d] got=%h exp=%h", j, got, exp);
          j++;
        end
      end
    end
  endtask

  task automatic test_accumulate();
    logic [1:0]   t_op [5];
    logic [W-1:0] t_a [5];
    logic [W-1:0] t_b [5];
    logic         t_clr [5];
    logic [W:0]   t_exp [5];
    bit ok, seen;
    int j;
    logic [W:0] got, exp;
    t_op  = '{OP_ACC, OP_ACC, OP_ACC, OP_ADD, OP_ACC};
    t_a   = '{16'd10, 16'd9, 16'd22, 16'd9, 16'd2};
    t_b   = '{16'h5555, 16'hAAAA, 16'h1234, 16'd9, 16'hFFFF};
    t_clr = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    t_exp = '{17'd10, 17'd19, 17'd41, 17'd18, 17'd2};
    j = 0;
    for (int i = 0; i < 5; i++) begin
      drive(t_op[i], t_a[i], t_b[i], t_clr[i], ok);
      n_checks++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL acc_accept[%0d]: got %b, expected 1", i, ok); end
      if (i == 2 || i == 4) begin
        while (j <= i) begin
          take(got, seen);
          exp = next_exp();
          n_checks++;
          if (!seen || got !== exp || got !== t_exp[j]) begin
            n_fail++;
            $display("FAIL acc_result[%0d]: got %h, expected %h (table %h)", j, got, exp, t_exp[j]);
          end
          $display("txn acc[%0d] got=%h exp=%h", j, got, exp);
          j++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n_acc;
    int pending[$];
    out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive(OP_ADD, 16'(100 * i + 3), 16'(11 * i), 1'b0, ok);
      if (ok) n_acc++;
      else pending.push_back(i);
    end
    n_checks++;
    if (n_acc != 4) begin n_fail++; $display("FAIL b2b_accepted: got %0d, expected 4", n_acc); end
    n_checks++;
    if ({in_ready, fifo_count} !== {1'b0, 3'd4}) begin
      n_fail++; $display("FAIL b2b_full: got ready=%b cnt=%0d, expected ready=0 cnt=4", in_ready, fifo_count);
    end
    fork
      begin
        for (int p = 0; p < pending.size(); p++) begin
          bit ok2;
          ok2 = 1'b0;
          for (int t = 0; t < 20 && !ok2; t++) begin
            drive(OP_ADD, 16'(100 * pending[p] + 3), 16'(11 * pending[p]), 1'b0, ok2);
          end
          n_checks++;
          if (ok2 !== 1'b1) begin n_fail++; $display("FAIL b2b_resend[%0d]: got %b, expected 1", p, ok2); end
        end
      end
      begin
        for (int k = 0; k < 6; k++) begin
          bit seen;
          logic [W:0] got, exp;
          take(got, seen);
          exp = next_exp();
          n_checks++;
          if (!seen || got !== exp) begin
            n_fail++; $display("FAIL b2b_result[%0d]: got %h, expected %h", k, got, exp);
          end
          $display("txn b2b[%0d] got=%h exp=%h", k, got, exp);
        end
      end
    join
    n_checks++;
    if (exp_q.size() != 0 || fifo_count !== '0) begin
      n_fail++; $display("FAIL b2b_drained: got queue=%0d cnt=%0d, expected 0 0", exp_q.size(), fifo_count);
    end
  endtask

  task automatic test_reset_midflight();
    bit ok, seen;
    logic [W:0] got, exp;
    out_ready = 1'b0;
    drive(OP_ACC, 16'd5, 16'd0, 1'b1, ok);
    drive(OP_ACC, 16'd6, 16'd0, 1'b0, ok);
    drive(OP_ACC, 16'd7, 16'd0, 1'b0, ok);
    drive(OP_ACC, 16'd8, 16'd0, 1'b0, ok);
    n_checks++;
    if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL mid_precount: got %0d, expected 3", fifo_count); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, fifo_count, result_data, overflow, in_ready} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h, expected 0",
               {out_valid, fifo_count, result_data, overflow, in_ready});
    end
    exp_q.delete();
    model_acc = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, fifo_count} !== '0) begin
      n_fail++; $display("FAIL mid_no_ghost: got v=%b cnt=%0d, expected 0 0", out_valid, fifo_count);
    end
    drive(OP_ACC, 16'd3, 16'd0, 1'b0, ok);
    take(got, seen);
    exp = next_exp();
    n_checks++;
    if (!seen || got !== exp || got !== 17'd3) begin
      n_fail++; $display("FAIL mid_acc_from_zero: got %h, expected %h", got, exp);
    end
    $display("txn mid_acc got=%h exp=%h", got, exp);
  endtask

  task automatic test_x_reset();
    bit ok, seen;
    logic [W:0] got, exp;
    reset = 1'bx;
    #10;
    reset = 1'b0;
    exp_q.delete();
    model_acc = '0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ($isunknown({out_valid, fifo_count, result_data, overflow, in_ready}) ||
        {out_valid, fifo_count, result_data, overflow, in_ready} !== {1'b0, 3'd0, 16'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL x_recover: got v=%b cnt=%h r=%h ovf=%b rdy=%b, expected 0 0 0 0 1",
               out_valid, fifo_count, result_data, overflow, in_ready);
    end
    @(negedge clk);
    drive(OP_ADD, 16'd22, 16'd21, 1'b0, ok);
    take(got, seen);
    exp = next_exp();
    n_checks++;
    if (!seen || got !== exp || got !== 17'd43) begin
      n_fail++; $display("FAIL x_add: got %h, expected %h", got, exp);
    end
    $display("txn x_add got=%h exp=%h", got, exp);
  endtask

  initial begin
    test_reset();
    test_add();
    test_arith();
    test_accumulate();
    test_back_to_back();
    test_reset_midflight();
    test_x_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
